cam_capture_ctrl: RTL



---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_byte_pack.sv | 66 ++++++
 rtl/cam_capture_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera frame-buffer write side.
//   cam_state_t   - capture sequencer states
//   CAM_WIDTH     - stored pixels per line
//   CAM_HEIGHT    - stored lines per frame
//   CAM_ADDR_W    - frame RAM address width
//   cam_pack_addr - {x, y} address layout, also decoded by the VGA read side
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } cam_state_t;

  localparam int unsigned CAM_WIDTH  = 160;
  localparam int unsigned CAM_HEIGHT = 120;
  localparam int unsigned CAM_ADDR_W = 15;

  function automatic logic [CAM_ADDR_W-1:0] cam_pack_addr(input logic [7:0] x,
                                                          input logic [6:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// cam_byte_pack: input register stage, href/vref edge detection and pairing
// of camera bytes into 16-bit RGB565 pixels.
//   clk, reset_n  - clock, synchronous active-low reset
//   pix_en        - camera byte strobe
//   href, vref    - line valid / vertical blank
//   digital       - camera byte
//   active        - sequencer is capturing; phase is held at 0 otherwise
//   pix_valid     - registered-stage byte completes a pixel this cycle
//   pix_data      - completed pixel {first byte, second byte}
//   href_fall, vref_rise, vref_fall - edges of the registered qualifiers
module cam_byte_pack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        href,
  input  logic        vref,
  input  logic [7:0]  digital,
  input  logic        active,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        href_fall,
  output logic        vref_rise,
  output logic        vref_fall
);

  logic       href_r, href_q;
  logic       vref_r, vref_q;
  logic       pix_en_r;
  logic [7:0] data_r;
  logic [7:0] hi_byte;
  logic       phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      href_r   <= 1'b0;
      href_q   <= 1'b0;
      vref_r   <= 1'b0;
      vref_q   <= 1'b0;
      pix_en_r <= 1'b0;
      data_r   <= '0;
      hi_byte  <= '0;
      phase    <= 1'b0;
    end else begin
      href_r   <= href;
      href_q   <= href_r;
      vref_r   <= vref;
      vref_q   <= vref_r;
      pix_en_r <= pix_en;
      data_r   <= digital;
      // Clearing on href fall drops an odd trailing byte of the line.
      if (!active || href_fall) begin
        phase <= 1'b0;
      end else if (href_r && pix_en_r) begin
        phase <= ~phase;
        if (!phase) hi_byte <= data_r;
      end
    end
  end

  assign href_fall = href_q & ~href_r;
  assign vref_rise = vref_r & ~vref_q;
  assign vref_fall = vref_q & ~vref_r;
  assign pix_valid = active & href_r & pix_en_r & phase;
  assign pix_data  = {hi_byte, data_r};

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: write-side sequencer for the camera frame buffer.
// Pairs camera bytes into RGB565 pixels, decimates by DECIM in both axes and
// drives the frame RAM write port with address {x[7:0], y[6:0]}.
//   clk, reset_n          - clock, synchronous active-low reset
//   pix_en, href, vref    - camera byte strobe, line valid, vertical blank
//   digital               - camera byte
//   pixel, wraddr, wren   - frame RAM write port (registered)
//   frame_done, frame_cnt - end-of-frame pulse, completed frame count
//   snap_req, snap_ack    - single-frame snapshot handshake
// Optional feature macro: CAM_SNAPSHOT_EN (snapshot/HOLD support). Without
// it, capture is continuous, snap_req is ignored and snap_ack is 0.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH  = CAM_WIDTH,
  parameter int unsigned HEIGHT = CAM_HEIGHT,
  parameter int unsigned DECIM  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_en,
  input  logic                  href,
  input  logic                  vref,
  input  logic [7:0]            digital,
  output logic [15:0]           pixel,
  output logic [CAM_ADDR_W-1:0] wraddr,
  output logic                  wren,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  input  logic                  snap_req,
  output logic                  snap_ack
);

  localparam logic [9:0] COL_MASK  = 10'(DECIM - 1);
  localparam logic [8:0] LINE_MASK = 9'(DECIM - 1);
  localparam logic [7:0] X_LIM     = 8'(WIDTH);
  localparam logic [6:0] Y_LIM     = 7'(HEIGHT);

  cam_state_t  state, state_next;
  logic        active;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        href_fall, vref_rise, vref_fall;
  logic [9:0]  raw_col;
  logic [8:0]  raw_line;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        line_kept;
  logic        keep;

  assign active = (state == ACTIVE);

  cam_byte_pack u_pack (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_en    (pix_en),
    .href      (href),
    .vref      (vref),
    .digital   (digital),
    .active    (active),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .href_fall (href_fall),
    .vref_rise (vref_rise),
    .vref_fall (vref_fall)
  );

`ifdef CAM_SNAPSHOT_EN
  logic armed;
  logic snap_frame;

  // A request only counts for a frame that starts after it was seen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      snap_frame <= 1'b0;
    end else begin
      if (state != HOLD && snap_req) armed <= 1'b1;
      if (state == SYNC && vref_fall) snap_frame <= armed | snap_req;
      if (active && vref_rise && snap_frame) begin
        armed      <= 1'b0;
        snap_frame <= 1'b0;
      end
    end
  end

  assign snap_ack = (state == HOLD);
`else
  logic unused_snap_req;
  assign unused_snap_req = snap_req;
  assign snap_ack        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:   if (vref_fall) state_next = ACTIVE;
      ACTIVE: if (vref_rise) begin
`ifdef CAM_SNAPSHOT_EN
        state_next = snap_frame ? HOLD : SYNC;
`else
        state_next = SYNC;
`endif
      end
`ifdef CAM_SNAPSHOT_EN
      HOLD:   if (!snap_req) state_next = SYNC;
`endif
      default: state_next = SYNC;
    endcase
  end

  assign line_kept = ((raw_line & LINE_MASK) == '0);
  assign keep      = ((raw_col & COL_MASK) == '0) && line_kept &&
                     (x < X_LIM) && (y < Y_LIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel      <= '0;
      wraddr     <= '0;
      wren       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      raw_col    <= '0;
      raw_line   <= '0;
      x          <= '0;
      y          <= '0;
    end else begin
      wren       <= 1'b0;
      frame_done <= 1'b0;
      if (state == SYNC && vref_fall) begin
        raw_col  <= '0;
        raw_line <= '0;
        x        <= '0;
        y        <= '0;
      end
      // A vref rise wins over a pixel completing in the same cycle.
      if (active && vref_rise) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end else if (active) begin
        if (pix_valid) begin
          raw_col <= raw_col + 10'd1;
          if (keep) begin
            wren   <= 1'b1;
            pixel  <= pix_data;
            wraddr <= cam_pack_addr(x, y);
            x      <= x + 8'd1;
          end
        end
        if (href_fall) begin
          raw_col  <= '0;
          x        <= '0;
          raw_line <= raw_line + 9'd1;
          if (line_kept && y < Y_LIM) y <= y + 7'd1;
        end
      end
    end
  end

endmodule
